fpmult_arbiter: RTL and testbench

- Shares one fixed-latency, fully pipelined FPMult instance among NREQ requesters.
- Arbitration is round-robin with a one-cycle valid/ready handshake per requester.
- Up to one operation issues per cycle; requester tags travel through a shift pipeline alongside the multiplier.
- Each result is returned on a shared response bus with a one-hot valid naming its owner.

---
 rtl/fpmult_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fpmult_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_arbiter.sv
// fpmult_arbiter: round-robin sharing of one fixed-latency, fully pipelined
// FPMult among NREQ requesters. The requester tag rides a shift pipeline
// that runs alongside the multiplier, so each product can be routed back to
// its owner on a shared, registered response bus.
module fpmult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      ReqValid,
  output logic [NREQ-1:0]      ReqReady,
  input  logic [32*NREQ-1:0]   ReqA,
  input  logic [32*NREQ-1:0]   ReqB,
  input  logic [3*NREQ-1:0]    ReqCtrl,
  output logic [31:0]          MultA,
  output logic [31:0]          MultB,
  output logic [2:0]           MultCtrl,
  output logic                 MultIssue,
  input  logic [31:0]          MultP,
  output logic [NREQ-1:0]      RspValid,
  output logic [31:0]          RspP,
  output logic                 Busy
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // (base + ofs) mod NREQ, with ofs < NREQ so one subtraction suffices.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                               input int unsigned   ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin pointer
  logic [IDW-1:0] ptr_q, ptr_d;

  // Issue stage registers
  logic [31:0]    mult_a_q, mult_a_d;
  logic [31:0]    mult_b_q, mult_b_d;
  logic [2:0]     mult_ctrl_q, mult_ctrl_d;
  logic           mult_issue_q, mult_issue_d;
  logic [IDW-1:0] issue_id_q, issue_id_d;

  // Tag pipeline, stage LATENCY-1 lines up with a valid MultP
  logic           tag_vld_q [LATENCY];
  logic           tag_vld_d [LATENCY];
  logic [IDW-1:0] tag_id_q  [LATENCY];
  logic [IDW-1:0] tag_id_d  [LATENCY];

  // Response registers
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_p_q, rsp_p_d;

  // Arbitration results
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [2:0]      sel_ctrl;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!grant_any && ReqValid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    // No grant is offered while reset is held.
    grant_any = grant_any & ~rst;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = grant_any && (grant_id == IDW'(i));
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = ReqA[32*i +: 32];
        sel_b    = ReqB[32*i +: 32];
        sel_ctrl = ReqCtrl[3*i +: 3];
      end
    end
  end

  // Pointer advance and issue-stage next state.
  always_comb begin
    ptr_d        = ptr_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    mult_ctrl_d  = mult_ctrl_q;
    issue_id_d   = issue_id_q;
    mult_issue_d = grant_any;
    if (grant_any) begin
      ptr_d       = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      mult_a_d    = sel_a;
      mult_b_d    = sel_b;
      mult_ctrl_d = sel_ctrl;
      issue_id_d  = grant_id;
    end
  end

  // Tag pipeline shift; stage 0 captures the op currently on MultA/B/Ctrl.
  always_comb begin
    for (int unsigned s = 0; s < LATENCY; s++) begin
      tag_vld_d[s] = 1'b0;
      tag_id_d[s]  = '0;
    end
    tag_vld_d[0] = mult_issue_q;
    tag_id_d[0]  = issue_id_q;
    for (int unsigned s = 1; s < LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  // Capture the product and name its owner when the last tag stage is valid.
  always_comb begin
    rsp_valid_d = '0;
    rsp_p_d     = rsp_p_q;
    if (tag_vld_q[LATENCY-1]) begin
      rsp_p_d = MultP;
      for (int unsigned i = 0; i < NREQ; i++) begin
        rsp_valid_d[i] = (tag_id_q[LATENCY-1] == IDW'(i));
      end
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_ctrl_q  <= '0;
      mult_issue_q <= 1'b0;
      issue_id_q   <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
      rsp_valid_q  <= '0;
      rsp_p_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      mult_ctrl_q  <= mult_ctrl_d;
      mult_issue_q <= mult_issue_d;
      issue_id_q   <= issue_id_d;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_d[s];
        tag_id_q[s]  <= tag_id_d[s];
      end
      rsp_valid_q  <= rsp_valid_d;
      rsp_p_q      <= rsp_p_d;
    end
  end

  // Busy while any op sits anywhere between issue and its response cycle.
  always_comb begin
    Busy = mult_issue_q | (|rsp_valid_q);
    for (int unsigned s = 0; s < LATENCY; s++) begin
      Busy = Busy | tag_vld_q[s];
    end
  end

  assign ReqReady  = grant;
  assign MultA     = mult_a_q;
  assign MultB     = mult_b_q;
  assign MultCtrl  = mult_ctrl_q;
  assign MultIssue = mult_issue_q;
  assign RspValid  = rsp_valid_q;
  assign RspP      = rsp_p_q;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Bench for fpmult_arbiter: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a small
// NREQ=1/LATENCY=1 instance.
module tb_fpmult_arbiter;
  localparam int N = 4;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [3*N-1:0]  req_ctrl;
  logic [31:0]     mult_a, mult_b, mult_p, rsp_p;
  logic [2:0]      mult_ctrl;
  logic            mult_issue, busy;
  logic [N-1:0]    rsp_valid;

  fpmult_arbiter #(.NREQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqA(req_a), .ReqB(req_b), .ReqCtrl(req_ctrl),
    .MultA(mult_a), .MultB(mult_b), .MultCtrl(mult_ctrl), .MultIssue(mult_issue),
    .MultP(mult_p), .RspValid(rsp_valid), .RspP(rsp_p), .Busy(busy));

  // Small second build: one requester, single-cycle multiplier
  logic        v1, rdy1, mi1, busy1, rv1;
  logic [31:0] a1, b1, ma1, mb1, mp1, rp1;
  logic [2:0]  c1, mc1;

  fpmult_arbiter #(.NREQ(1), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ReqValid(v1), .ReqReady(rdy1),
    .ReqA(a1), .ReqB(b1), .ReqCtrl(c1),
    .MultA(ma1), .MultB(mb1), .MultCtrl(mc1), .MultIssue(mi1),
    .MultP(mp1), .RspValid(rv1), .RspP(rp1), .Busy(busy1));

  // Simplified float multiply for normal operands (truncating); the ctrl
  // bits are folded into the LSBs so a mis-routed ctrl shows up.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] c);
    logic [47:0] pr;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0} ^ {29'd0, c};
    pr = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e  = {2'd0, a[30:23]} + {2'd0, b[30:23]} - 10'd127;
    if (pr[47]) begin
      m = pr[46:24];
      e = e + 10'd1;
    end else begin
      m = pr[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m} ^ {29'd0, c};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'(100 + $urandom_range(0, 54));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // External multiplier models: fixed-latency pipelines, garbage when idle
  logic        sv [L];
  logic [31:0] sp [L];
  logic        sv1;
  logic [31:0] sp1, junk;
  always @(posedge clk) begin
    sv[0] <= mult_issue;
    sp[0] <= fmul(mult_a, mult_b, mult_ctrl);
    for (int s = 1; s < L; s++) begin
      sv[s] <= sv[s-1];
      sp[s] <= sp[s-1];
    end
    sv1  <= mi1;
    sp1  <= fmul(ma1, mb1, mc1);
    junk <= $urandom;
  end
  assign mult_p = sv[L-1] ? sp[L-1] : junk;
  assign mp1    = sv1 ? sp1 : junk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: pointer, last issued operands and a queue of in-flight
  // ops each carrying its issue cycle and the cycle its response must show.
  typedef struct {
    int          start;
    int          due;
    int          id;
    logic [31:0] p;
  } ent_t;

  ent_t        q[$];
  int          m_ptr   = 0;
  int          last_hs = -10;
  int          cyc     = 0;
  logic [31:0] la = '0, lb = '0, lp = '0;
  logic [2:0]  lc = '0;

  always @(negedge clk) begin
    int         g;
    logic [N-1:0] eg, erv;
    logic       eb;
    cyc++;
    if (rst) begin
      m_ptr = 0; last_hs = -10; la = '0; lb = '0; lc = '0; lp = '0;
      q.delete();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_issue", 32'(mult_issue), 32'd0);
      chk("rst_multa", mult_a, 32'd0);
      chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
      chk("rst_rspp", rsp_p, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      eg  = (g >= 0) ? N'(1 << g) : '0;
      erv = '0;
      eb  = 1'b0;
      foreach (q[j]) begin
        if (q[j].due == cyc) begin
          erv = N'(1 << q[j].id);
          lp  = q[j].p;
        end
        if (q[j].start <= cyc && cyc <= q[j].due) eb = 1'b1;
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      chk("ready", 32'(req_ready), 32'(eg));
      chk("issue", 32'(mult_issue), 32'(last_hs == cyc - 1));
      chk("multa", mult_a, la);
      chk("multb", mult_b, lb);
      chk("multctrl", 32'(mult_ctrl), 32'(lc));
      chk("rspvalid", 32'(rsp_valid), 32'(erv));
      chk("rspp", rsp_p, lp);
      chk("busy", 32'(busy), 32'(eb));
      if (g >= 0) begin
        la = req_a[g*32 +: 32];
        lb = req_b[g*32 +: 32];
        lc = req_ctrl[g*3 +: 3];
        q.push_back('{cyc + 1, cyc + L + 2, g, fmul(la, lb, lc)});
        last_hs = cyc;
        m_ptr   = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = rand_fp();
      req_b[i*32 +: 32] = rand_fp();
      req_ctrl[i*3 +: 3] = 3'($urandom);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp1;

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1.0 * 2.0 from requester 0, latency LATENCY+2
    req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_ctrl[2:0] = 3'd0;
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1 chk("t1_issue", 32'(mult_issue), 32'd1);
    chk("t1_multa", mult_a, 32'h3F80_0000);
    for (int i = 0; i < L; i++) begin
      tick();
      #1 chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
    end
    tick();
    #1 chk("t1_rspvalid", 32'(rsp_valid), 32'h1);
    chk("t1_rspp", rsp_p, 32'h4000_0000);
    tick();
    #1 chk("t1_rsp_after", 32'(rsp_valid), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // All four requesting: strict rotation from pointer 0
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      req_valid = 4'hF;
      #1 chk("t2_grant", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
    end
    req_valid = '0;
    repeat (L + 3) tick();

    // Pointer lands on 2 after granting 1; 3 then 0 win next, never 1
    rand_ops();
    req_valid = 4'b0010;
    #1 chk("t3_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1001;
    #1 chk("t3_grant3", 32'(req_ready), 32'h8);
    tick();
    #1 chk("t3_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (L + 3) tick();

    // Requester 2 back to back for 5 cycles
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      req_valid = 4'b0100;
      #1 chk("t4_grant", 32'(req_ready), 32'h4);
      tick();
    end
    req_valid = '0;
    for (int j = 0; j < L + 1; j++) begin
      #1 chk("t4_busy", 32'(busy), 32'd1);
      tick();
    end
    #1 chk("t4_last_rsp", 32'(rsp_valid), 32'h4);
    chk("t4_busy_last", 32'(busy), 32'd1);
    tick();
    #1 chk("t4_busy_clear", 32'(busy), 32'd0);

    // Asynchronous reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      req_valid = 4'hF;
      tick();
    end
    req_valid = '0;
    #1 rst = 1'b1;
    #1 chk("t5_issue", 32'(mult_issue), 32'd0);
    chk("t5_multa", mult_a, 32'd0);
    chk("t5_rspvalid", 32'(rsp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    repeat (L + 4) tick();
    rand_ops();
    req_valid = 4'hF;
    #1 chk("t5_ptr_reset", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (L + 3) tick();

    // Randomized traffic with rare resets
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      req_valid = N'($urandom);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else tick();
    end
    req_valid = '0;
    repeat (L + 3) tick();

    // NREQ=1, LATENCY=1 build
    a1 = rand_fp(); b1 = rand_fp(); c1 = 3'($urandom);
    exp1 = fmul(a1, b1, c1);
    #1 chk("t6_ready_idle", 32'(rdy1), 32'd0);
    v1 = 1'b1;
    #1 chk("t6_ready", 32'(rdy1), 32'd1);
    tick();
    v1 = 1'b0;
    #1 chk("t6_ready_drop", 32'(rdy1), 32'd0);
    chk("t6_issue", 32'(mi1), 32'd1);
    tick();
    #1 chk("t6_rsp_early", 32'(rv1), 32'd0);
    tick();
    #1 chk("t6_rspvalid", 32'(rv1), 32'd1);
    chk("t6_rspp", rp1, exp1);
    tick();
    #1 chk("t6_busy_clear", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
